update_line_packer: RTL and testbench
=====================================

// Module: update_line_packer
// PURPOSE
//  Write-side partner of the 64-bank byte-read line memory. Takes a stream of
//  byte-granular BFS updates {byte address, value} and merges them into
//  512-bit lines. Each line carries a 64-bit byte mask and goes out as one
//  line write. Sits between the BFS update engine and the line write port
//  (BRAM w_addr/data_in, or the DRAM write-back path).
// PARAMETERS
//  ADDR_W     10     line address width; byte address width is ADDR_W+6
//  FILL_BYTE  8'hdd  value driven on out_data byte lanes whose mask bit is 0
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst_n      in   1          synchronous active-low reset
//  in_valid   in   1          update present
//  in_ready   out  1          update accepted when in_valid&in_ready
//  in_addr    in   ADDR_W+6   byte address; [ADDR_W+5:6]=line, [5:0]=lane
//  in_data    in   8          byte value
//  flush      in   1          level; drain all buffered data
//  out_valid  out  1          line write present
//  out_ready  in   1          line write consumed when out_valid&out_ready
//  out_addr   out  ADDR_W     line address
//  out_data   out  512        line data; lane k = out_data[8k+7:8k]
//  out_mask   out  64         bit k=1: lane k written
//  idle       out  1          no line buffered and no output pending
// BEHAVIOUR
//  - Storage: one line buffer (addr, 512b data, 64b mask) and one registered
//    output slot. FSM states: EMPTY (mask==0) and FILL (mask!=0).
//  - Reset (rst_n=0 at posedge): state=EMPTY; out_valid=0, out_addr=0,
//    out_mask=0, out_data=all FILL_BYTE; buffer mask cleared. Takes effect
//    mid-operation; any buffered or pending lines are discarded.
//  - slot_free = !out_valid | out_ready (slot is freed in the same cycle).
//  - in_ready = !flush & (state==EMPTY | line hit | slot_free).
//    line hit = in_addr line == buffer line.
//  - EMPTY + accept: load line addr, set lane byte and mask bit -> FILL.
//  - FILL + accept with line hit: overwrite the lane byte and set its mask bit.
//    Last write wins; stay in FILL.
//  - FILL + accept with line miss: move the buffer to the output slot
//    (out_valid=1 at the next edge). In the same cycle, load the new update
//    into the buffer as a fresh line; stay in FILL.
//  - Full line: if a line-hit merge makes the mask all ones and slot_free,
//    the merged line goes to the output at that edge -> EMPTY. If the slot is
//    not free, the line stays in FILL and is evicted later by a miss or flush.
//  - flush=1: in_ready=0. In FILL with slot_free, move buffer to output ->
//    EMPTY. Flush is done when idle=1; the requester holds flush until then.
//  - out_data lanes with mask=0 carry FILL_BYTE. The slot holds its value
//    while out_valid&!out_ready.
//  - Latency: an evicted line is visible on out_* one cycle after the
//    evicting edge. Line writes come out in eviction order; nothing is dropped.
//  - idle = (state==EMPTY) & !out_valid.
// CONFIGURATION
//  PACKER_STATS_EN defined: adds outputs stat_updates[31:0] (accepted
//    updates) and stat_lines[31:0] (out_valid&out_ready handshakes). Both
//    counters clear on reset and wrap modulo 2^32.
//  Not defined: these ports and counters do not exist. All other behaviour
//    is identical.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> out_valid=0, in_ready=1, idle=1,
//    out_data=all 8'hdd.
//  2 Merge: bytes 0x40:01, 0x45:02, 0x40:03, then flush -> one write:
//    out_addr=1, mask=64'h21, lane0=03, lane5=02, other lanes dd.
//  3 Miss: 0x000:AA then 0x080:BB, out_ready=1 -> out_addr=0, mask=1,
//    lane0=AA. After flush, out_addr=2, lane0=BB.
//  4 Backpressure: out_ready=0 with slot full, then a miss update ->
//    in_ready=0, out_* stable. Raise out_ready -> update accepted that cycle.
//  5 Full line: 64 updates to line 3, lanes 0..63, value=lane -> out_valid
//    with mask=all ones one cycle after the 64th; state EMPTY, idle=1 after
//    the handshake.
//  6 Reset mid-fill: 5 updates, rst_n=0 for 1 cycle, then flush -> no line
//    write emitted; stats (if enabled) read 0.

Source files
------------

// File: rtl/update_line_packer.sv
// update_line_packer: merges byte-granular {address, value} updates into
// 512-bit masked line writes. It has one line buffer and one registered output slot.
// Optional statistics counters are built when PACKER_STATS_EN is defined.
module update_line_packer #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  FILL_BYTE = 8'hdd
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W+5:0]   in_addr,
  input  logic [7:0]          in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [511:0]        out_data,
  output logic [63:0]         out_mask,
  output logic                idle
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_lines
`endif
);

  typedef enum logic {EMPTY, FILL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [511:0]        buf_data_q, buf_data_d;
  logic [63:0]         buf_mask_q, buf_mask_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [511:0]        out_data_q, out_data_d;
  logic [63:0]         out_mask_q, out_mask_d;

  logic [ADDR_W-1:0]   in_line;
  logic [5:0]          in_lane;
  logic                line_hit;
  logic                slot_free;
  logic                accept;
  logic [511:0]        merged_data;
  logic [63:0]         merged_mask;

  // Lanes that were never written carry the fill byte on the output.
  function automatic logic [511:0] apply_fill(input logic [511:0] d, input logic [63:0] m);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      r[8*k +: 8] = m[k] ? d[8*k +: 8] : FILL_BYTE;
    end
    return r;
  endfunction

  assign in_line   = in_addr[ADDR_W+5:6];
  assign in_lane   = in_addr[5:0];
  assign line_hit  = (in_line == buf_addr_q);
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !flush && ((state_q == EMPTY) || line_hit || slot_free);
  assign accept    = in_valid && in_ready;
  assign idle      = (state_q == EMPTY) && !out_valid_q;

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;

  // Buffer contents if the incoming byte is written into the current line.
  always_comb begin
    merged_data = buf_data_q;
    merged_mask = buf_mask_q;
    merged_data[{in_lane, 3'b000} +: 8] = in_data;
    merged_mask[in_lane] = 1'b1;
  end

  // Next-state logic for the buffer, the output slot and the EMPTY/FILL state.
  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      EMPTY: begin
        if (accept) begin
          buf_addr_d = in_line;
          buf_data_d = '0;
          buf_data_d[{in_lane, 3'b000} +: 8] = in_data;
          buf_mask_d = 64'd1 << in_lane;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_addr_d  = buf_addr_q;
            out_data_d  = apply_fill(buf_data_q, buf_mask_q);
            out_mask_d  = buf_mask_q;
            buf_mask_d  = '0;
            state_d     = EMPTY;
          end
        end else if (accept && line_hit) begin
          if ((&merged_mask) && slot_free) begin
            out_valid_d = 1'b1;
            out_addr_d  = buf_addr_q;
            out_data_d  = apply_fill(merged_data, merged_mask);
            out_mask_d  = merged_mask;
            buf_mask_d  = '0;
            state_d     = EMPTY;
          end else begin
            buf_data_d = merged_data;
            buf_mask_d = merged_mask;
          end
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_addr_d  = buf_addr_q;
          out_data_d  = apply_fill(buf_data_q, buf_mask_q);
          out_mask_d  = buf_mask_q;
          buf_addr_d  = in_line;
          buf_data_d  = '0;
          buf_data_d[{in_lane, 3'b000} +: 8] = in_data;
          buf_mask_d  = 64'd1 << in_lane;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, buffer and output slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_mask_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= {64{FILL_BYTE}};
      out_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_mask_q  <= buf_mask_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
    end
  end

`ifdef PACKER_STATS_EN
  logic [31:0] stat_updates_q, stat_lines_q;

  assign stat_updates = stat_updates_q;
  assign stat_lines   = stat_lines_q;

  // Count accepted updates and completed line-write handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_updates_q <= '0;
      stat_lines_q   <= '0;
    end else begin
      if (accept) stat_updates_q <= stat_updates_q + 32'd1;
      if (out_valid_q && out_ready) stat_lines_q <= stat_lines_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_update_line_packer.sv
// Testbench for update_line_packer: directed updates, with expected line
// writes pushed to a scoreboard queue and checked by a separate monitor.
module tb_update_line_packer;

  localparam int ADDR_W = 10;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [511:0]      data;
    logic [63:0]       mask;
  } line_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W+5:0]   in_addr;
  logic [7:0]          in_data;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_addr;
  logic [511:0]        out_data;
  logic [63:0]         out_mask;
  logic                idle;
`ifdef PACKER_STATS_EN
  logic [31:0]         stat_updates;
  logic [31:0]         stat_lines;
`endif

  int checks = 0;
  int failures = 0;
  int linesSeen = 0;
  line_t expQ[$];

  update_line_packer #(.ADDR_W(ADDR_W), .FILL_BYTE(8'hdd)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_mask(out_mask), .idle(idle)
`ifdef PACKER_STATS_EN
    , .stat_updates(stat_updates), .stat_lines(stat_lines)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report a failure line if it differs.
  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one update and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [ADDR_W+5:0] addr, input logic [7:0] data);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = addr;
    in_data  = data;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 512'd0, 512'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Hold flush until the packer reports idle (bounded wait).
  task automatic doFlush();
    int n;
    @(posedge clk); #1;
    flush = 1'b1;
    n = 0;
    @(negedge clk);
    while (!idle && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!idle) checkOutput("flush_timeout", 512'd0, 512'd1);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Line with only lane 0 written, other lanes at the fill byte.
  function automatic line_t oneByteLine(input logic [ADDR_W-1:0] a, input logic [7:0] b);
    line_t l;
    l.addr = a;
    l.data = {64{8'hdd}};
    l.data[7:0] = b;
    l.mask = 64'h1;
    return l;
  endfunction

  // Monitor: on every output handshake pop the scoreboard and compare.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      linesSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_line", {502'd0, out_addr}, 512'h0);
        checkOutput("unexpected_line_valid", 512'd1, 512'd0);
      end else begin
        line_t e;
        e = expQ.pop_front();
        checkOutput("out_addr", {502'd0, out_addr}, {502'd0, e.addr});
        checkOutput("out_mask", {448'd0, out_mask}, {448'd0, e.mask});
        checkOutput("out_data", out_data, e.data);
      end
    end
  end

  // Directed test sequence.
  initial begin
    line_t l;
    int seenBefore;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", {511'd0, out_valid}, 512'd0);
    checkOutput("reset_in_ready", {511'd0, in_ready}, 512'd1);
    checkOutput("reset_idle", {511'd0, idle}, 512'd1);
    checkOutput("reset_out_data", out_data, {64{8'hdd}});
    checkOutput("reset_out_mask", {448'd0, out_mask}, 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Merge within one line, last write wins.
    l.addr = 10'd1;
    l.data = {64{8'hdd}};
    l.data[7:0]   = 8'h03;
    l.data[47:40] = 8'h02;
    l.mask = 64'h21;
    expQ.push_back(l);
    applyStimulus(16'h0040, 8'h01);
    applyStimulus(16'h0045, 8'h02);
    applyStimulus(16'h0040, 8'h03);
    doFlush();

    // Line miss evicts the previous line.
    expQ.push_back(oneByteLine(10'd0, 8'hAA));
    expQ.push_back(oneByteLine(10'd2, 8'hBB));
    applyStimulus(16'h0000, 8'hAA);
    applyStimulus(16'h0080, 8'hBB);
    doFlush();

    // Backpressure: slot full and a miss arrives.
    expQ.push_back(oneByteLine(10'd3, 8'h11));
    expQ.push_back(oneByteLine(10'd4, 8'h22));
    expQ.push_back(oneByteLine(10'd5, 8'h33));
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(16'h00C0, 8'h11);
    applyStimulus(16'h0100, 8'h22);
    @(posedge clk); #1;
    in_valid = 1'b1; in_addr = 16'h0140; in_data = 8'h33;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {511'd0, in_ready}, 512'd0);
      checkOutput("bp_out_valid", {511'd0, out_valid}, 512'd1);
      checkOutput("bp_out_addr", {502'd0, out_addr}, 512'd3);
      checkOutput("bp_out_mask", {448'd0, out_mask}, 512'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", {511'd0, in_ready}, 512'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    doFlush();

    // Full line of 64 updates auto-evicts.
    l.addr = 10'd3;
    l.mask = {64{1'b1}};
    for (int k = 0; k < 64; k++) l.data[8*k +: 8] = 8'(k);
    expQ.push_back(l);
    for (int k = 0; k < 64; k++) applyStimulus(16'(192 + k), 8'(k));
    checkOutput("full_out_valid", {511'd0, out_valid}, 512'd1);
    @(posedge clk); #1;
    checkOutput("full_idle", {511'd0, idle}, 512'd1);

    // Reset in the middle of filling discards the line.
    seenBefore = linesSeen;
    for (int k = 0; k < 5; k++) applyStimulus(16'(448 + k), 8'(k + 1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    doFlush();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_no_line", 512'(linesSeen), 512'(seenBefore));
    checkOutput("midreset_idle", {511'd0, idle}, 512'd1);
`ifdef PACKER_STATS_EN
    checkOutput("stat_updates", {480'd0, stat_updates}, 512'd0);
    checkOutput("stat_lines", {480'd0, stat_lines}, 512'd0);
`endif
    checkOutput("scoreboard_empty", 512'(expQ.size()), 512'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
